// File: rtl/sprite_scaler_renderer_if.sv
// Bundle of the renderer's per-scanline control, ROM bus and pixel outputs.
// Control inputs are level-sampled on the rising clock edge and need no handshake.
// rom_bits must follow rom_addr after ROM_LAT clocks.
interface sprite_scaler_renderer_if #(
  parameter int ADDR_W = 3,
  parameter int ROM_W  = 8
);
  logic              vstart;
  logic              load;
  logic              hstart;
  logic              hflip;
  logic              vflip;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_bits;
  logic              gfx;
  logic              in_progress;
  logic              done;
  logic [2:0]        state_dbg;

  modport master (
    output vstart, load, hstart, hflip, vflip, rom_bits,
    input  rom_addr, gfx, in_progress, done, state_dbg
  );

  modport slave (
    input  vstart, load, hstart, hflip, vflip, rom_bits,
    output rom_addr, gfx, in_progress, done, state_dbg
  );
endinterface

// File: rtl/sprite_scaler_renderer.sv
// Single-sprite scanline renderer: fetches one ROM row per line during hsync and
// shifts it out from hstart with optional mirroring, flipping and integer scaling.
module sprite_scaler_renderer #(
  parameter int ROM_W      = 8,
  parameter int ROM_H      = 8,
  parameter int MIRROR_X   = 1,
  parameter int MIRROR_Y   = 1,
  parameter int SCALE_LOG2 = 0,
  parameter int ROM_LAT    = 0,
  localparam int ADDR_W    = $clog2(ROM_H)
) (
  input  logic                     clk,
  input  logic                     reset,
  sprite_scaler_renderer_if.slave  bus
);

  localparam int COLS        = ROM_W << MIRROR_X;
  localparam int ROWS        = ROM_H << MIRROR_Y;
  localparam int LINE_CLKS   = COLS << SCALE_LOG2;
  localparam int FRAME_LINES = ROWS << SCALE_LOG2;
  localparam int XW          = $clog2(LINE_CLKS + 1);
  localparam int YW          = $clog2(FRAME_LINES + 1);
  localparam int IW          = $clog2(ROM_W);
  localparam int LW          = $clog2(ROM_LAT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOAD   = 3'd1,
    SETUP       = 3'd2,
    FETCH       = 3'd3,
    WAIT_HSTART = 3'd4,
    DRAW        = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     xcount_q, xcount_d;
  logic [YW-1:0]     ycount_q, ycount_d;
  logic              hflip_q, hflip_d;
  logic              vflip_q, vflip_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_W-1:0]  outbits_q, outbits_d;
  logic [LW-1:0]     fetch_q, fetch_d;
  logic              gfx_q, gfx_d;
  logic              done_q, done_d;

  logic [YW-1:0]     row_s, row_f;
  logic [ADDR_W-1:0] row_addr;
  logic [XW-1:0]     col_s, col_f, col_idx;
  logic              pix;

  // Row/column selection: scale down, apply flip, then fold the mirrored half.
  always_comb begin
    row_s = ycount_q >> SCALE_LOG2;
    row_f = vflip_q ? (YW'(ROWS - 1) - row_s) : row_s;
    if (MIRROR_Y != 0 && row_f >= YW'(ROM_H)) begin
      row_addr = ADDR_W'(YW'(2 * ROM_H - 1) - row_f);
    end else begin
      row_addr = ADDR_W'(row_f);
    end
    col_s = xcount_q >> SCALE_LOG2;
    col_f = hflip_q ? (XW'(COLS - 1) - col_s) : col_s;
    if (MIRROR_X != 0 && col_f >= XW'(ROM_W)) begin
      col_idx = XW'(2 * ROM_W - 1) - col_f;
    end else begin
      col_idx = col_f;
    end
    pix = outbits_q[IW'(col_idx)];
  end

  always_comb begin
    state_d    = state_q;
    xcount_d   = xcount_q;
    ycount_d   = ycount_q;
    hflip_d    = hflip_q;
    vflip_d    = vflip_q;
    rom_addr_d = rom_addr_q;
    outbits_d  = outbits_q;
    fetch_d    = fetch_q;
    gfx_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        ycount_d = '0;
        if (bus.vstart) begin
          hflip_d = bus.hflip;
          vflip_d = bus.vflip;
          state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        xcount_d = '0;
        if (bus.load) state_d = SETUP;
      end
      SETUP: begin
        rom_addr_d = row_addr;
        fetch_d    = '0;
        state_d    = FETCH;
      end
      FETCH: begin
        // Wait out the ROM latency; rom_bits is valid on the final count.
        if (fetch_q == LW'(ROM_LAT)) begin
          outbits_d = bus.rom_bits;
          state_d   = WAIT_HSTART;
        end else begin
          fetch_d = fetch_q + 1'b1;
        end
      end
      WAIT_HSTART: begin
        if (bus.hstart) state_d = DRAW;
      end
      DRAW: begin
        gfx_d    = pix;
        xcount_d = xcount_q + 1'b1;
        if (xcount_q == XW'(LINE_CLKS - 1)) begin
          ycount_d = ycount_q + 1'b1;
          if (ycount_q == YW'(FRAME_LINES - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      xcount_q   <= '0;
      ycount_q   <= '0;
      hflip_q    <= 1'b0;
      vflip_q    <= 1'b0;
      rom_addr_q <= '0;
      outbits_q  <= '0;
      fetch_q    <= '0;
      gfx_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      xcount_q   <= xcount_d;
      ycount_q   <= ycount_d;
      hflip_q    <= hflip_d;
      vflip_q    <= vflip_d;
      rom_addr_q <= rom_addr_d;
      outbits_q  <= outbits_d;
      fetch_q    <= fetch_d;
      gfx_q      <= gfx_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.gfx         = gfx_q;
  assign bus.done        = done_q;
  assign bus.in_progress = (state_q != IDLE);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sprite_scaler_renderer.sv
// Bench for sprite_scaler_renderer: four parameterisations run side by side on a
// shared scanline schedule, each scanline checked against a per-instance sprite model.
module tb_sprite_scaler_renderer;

  localparam int HS = 5;
  localparam int P_RW  [4] = '{8, 16, 8, 8};
  localparam int P_RH  [4] = '{8, 16, 8, 8};
  localparam int P_MX  [4] = '{1, 0, 1, 1};
  localparam int P_MY  [4] = '{1, 0, 1, 1};
  localparam int P_SL  [4] = '{0, 0, 1, 0};
  localparam int P_LAT [4] = '{0, 0, 0, 2};
  localparam logic [63:0] LINE0_1X = 64'h0000_0000_0030_00C0;
  localparam logic [63:0] LINE0_2X = 64'h0000_003C_0000_03C0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       vstart, load, hstart;
  logic [3:0] hf_v, vf_v;
  logic [15:0] rom [4][16];
  logic [7:0]  d1, d2;

  int vectors;
  int miscompares;
  logic [63:0] exp_q[$];
  logic [63:0] keep_g [4][32];
  int          keep_a [4][32];
  int          keep_f [4][32];

  sprite_scaler_renderer_if #(.ADDR_W(3), .ROM_W(8))  if_a ();
  sprite_scaler_renderer_if #(.ADDR_W(4), .ROM_W(16)) if_b ();
  sprite_scaler_renderer_if #(.ADDR_W(3), .ROM_W(8))  if_c ();
  sprite_scaler_renderer_if #(.ADDR_W(3), .ROM_W(8))  if_d ();

  assign if_a.vstart = vstart; assign if_a.load = load; assign if_a.hstart = hstart;
  assign if_b.vstart = vstart; assign if_b.load = load; assign if_b.hstart = hstart;
  assign if_c.vstart = vstart; assign if_c.load = load; assign if_c.hstart = hstart;
  assign if_d.vstart = vstart; assign if_d.load = load; assign if_d.hstart = hstart;
  assign if_a.hflip = hf_v[0]; assign if_a.vflip = vf_v[0];
  assign if_b.hflip = hf_v[1]; assign if_b.vflip = vf_v[1];
  assign if_c.hflip = hf_v[2]; assign if_c.vflip = vf_v[2];
  assign if_d.hflip = hf_v[3]; assign if_d.vflip = vf_v[3];

  // Combinational ROMs for a/b/c, two-stage registered ROM for d.
  assign if_a.rom_bits = rom[0][{1'b0, if_a.rom_addr}][7:0];
  assign if_b.rom_bits = rom[1][if_b.rom_addr];
  assign if_c.rom_bits = rom[2][{1'b0, if_c.rom_addr}][7:0];
  always @(posedge clk) begin
    d1 <= rom[3][{1'b0, if_d.rom_addr}][7:0];
    d2 <= d1;
  end
  assign if_d.rom_bits = d2;

  sprite_scaler_renderer #(.ROM_W(8), .ROM_H(8), .MIRROR_X(1), .MIRROR_Y(1), .SCALE_LOG2(0), .ROM_LAT(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  sprite_scaler_renderer #(.ROM_W(16), .ROM_H(16), .MIRROR_X(0), .MIRROR_Y(0), .SCALE_LOG2(0), .ROM_LAT(0))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  sprite_scaler_renderer #(.ROM_W(8), .ROM_H(8), .MIRROR_X(1), .MIRROR_Y(1), .SCALE_LOG2(1), .ROM_LAT(0))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));
  sprite_scaler_renderer #(.ROM_W(8), .ROM_H(8), .MIRROR_X(1), .MIRROR_Y(1), .SCALE_LOG2(0), .ROM_LAT(2))
    dut_d (.clk(clk), .reset(reset), .bus(if_d));

  wire [3:0] gfx_w   = {if_d.gfx, if_c.gfx, if_b.gfx, if_a.gfx};
  wire [3:0] done_w  = {if_d.done, if_c.done, if_b.done, if_a.done};
  wire [3:0] ip_w    = {if_d.in_progress, if_c.in_progress, if_b.in_progress, if_a.in_progress};
  wire [3:0] fetch_w = {if_d.state_dbg == 3'd3, if_c.state_dbg == 3'd3,
                        if_b.state_dbg == 3'd3, if_a.state_dbg == 3'd3};

  function automatic int dut_addr(input int d);
    int r;
    case (d)
      0:       r = int'(if_a.rom_addr);
      1:       r = int'(if_b.rom_addr);
      2:       r = int'(if_c.rom_addr);
      default: r = int'(if_d.rom_addr);
    endcase
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Screen line y -> ROM row, following the sprite's fold/flip geometry.
  function automatic int m_addr(input int y, input int rh, input int my, input int sl, input bit vf);
    int rows = rh << my;
    int r = y >> sl;
    if (vf) r = rows - 1 - r;
    if (my != 0 && r >= rh) r = 2 * rh - 1 - r;
    return r;
  endfunction

  function automatic bit m_pix(input logic [15:0] bits, input int x, input int rw, input int mx,
                               input int sl, input bit hf);
    int cols = rw << mx;
    int c = x >> sl;
    if (hf) c = cols - 1 - c;
    if (mx != 0 && c >= rw) c = 2 * rw - 1 - c;
    return bits[c];
  endfunction

  // ---------------- driver + scoreboard for one frame ----------------
  task automatic run_frame(input logic [3:0] hfs, input logic [3:0] vfs,
                           input int rst_line, input int glitch_line);
    logic [63:0] gcap [4];
    logic [63:0] dcap [4];
    logic [63:0] eg, ed;
    int fcap [4], acap [4], done_cnt [4];
    bit ipcap [4];
    int n_clk, n_lin, ea;
    hf_v = hfs;
    vf_v = vfs;
    vstart = 1'b1;
    @(posedge clk); #1;
    vstart = 1'b0;
    for (int d = 0; d < 4; d++) done_cnt[d] = 0;
    for (int y = 0; y < 32; y++) begin
      for (int d = 0; d < 4; d++) begin
        n_clk = (P_RW[d] << P_MX[d]) << P_SL[d];
        n_lin = (P_RH[d] << P_MY[d]) << P_SL[d];
        eg = '0;
        ed = '0;
        if (y < n_lin) begin
          ea = m_addr(y, P_RH[d], P_MY[d], P_SL[d], vfs[d]);
          for (int n = 0; n < n_clk; n++) eg[HS + 1 + n] = m_pix(rom[d][ea], n, P_RW[d], P_MX[d], P_SL[d], hfs[d]);
          if (y == n_lin - 1) ed[HS + n_clk] = 1'b1;
        end
        exp_q.push_back(eg);
        exp_q.push_back(ed);
        gcap[d] = '0; dcap[d] = '0; fcap[d] = 0; acap[d] = 0; ipcap[d] = 1'b0;
      end
      for (int k = 0; k < 64; k++) begin
        load   = (k == 0);
        hstart = (k == HS);
        vstart = (y == glitch_line && k == HS + 4);
        if (vstart) begin
          hf_v = ~hf_v;
          vf_v = ~vf_v;
        end
        @(posedge clk); #1;
        if (y == rst_line && k == HS + 3) begin
          reset = 1'b1;
          #1;
          vectors++;
          if ((gfx_w | ip_w | done_w) !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset gfx=%b in_progress=%b done=%b required all 0", gfx_w, ip_w, done_w);
          end
          load = 1'b0; hstart = 1'b0; vstart = 1'b0;
          exp_q.delete();
          repeat (2) @(posedge clk);
          #1 reset = 1'b0;
          return;
        end
        for (int d = 0; d < 4; d++) begin
          gcap[d][k] = gfx_w[d];
          dcap[d][k] = done_w[d];
          fcap[d] += int'(fetch_w[d]);
          if (k == HS) acap[d] = dut_addr(d);
          if (k == 63) ipcap[d] = ip_w[d];
        end
      end
      for (int d = 0; d < 4; d++) begin
        n_lin = (P_RH[d] << P_MY[d]) << P_SL[d];
        eg = exp_q.pop_front();
        ed = exp_q.pop_front();
        vectors++;
        if (gcap[d] !== eg) begin
          miscompares++;
          $display("FAIL line_gfx dut=%0d line=%0d got %h required %h", d, y, gcap[d], eg);
        end
        vectors++;
        if (dcap[d] !== ed) begin
          miscompares++;
          $display("FAIL line_done dut=%0d line=%0d got %h required %h", d, y, dcap[d], ed);
        end
        vectors++;
        if (ipcap[d] !== (y < n_lin - 1)) begin
          miscompares++;
          $display("FAIL in_progress dut=%0d line=%0d got %0d required %0d", d, y, ipcap[d], (y < n_lin - 1));
        end
        if (y < n_lin) begin
          ea = m_addr(y, P_RH[d], P_MY[d], P_SL[d], vfs[d]);
          vectors++;
          if (acap[d] !== ea) begin
            miscompares++;
            $display("FAIL rom_addr dut=%0d line=%0d got %0d required %0d", d, y, acap[d], ea);
          end
          vectors++;
          if (fcap[d] !== P_LAT[d] + 1) begin
            miscompares++;
            $display("FAIL fetch_len dut=%0d line=%0d got %0d required %0d", d, y, fcap[d], P_LAT[d] + 1);
          end
        end
        done_cnt[d] += $countones(dcap[d]);
        keep_g[d][y] = gcap[d];
        keep_a[d][y] = acap[d];
        keep_f[d][y] = fcap[d];
      end
    end
    load = 1'b0;
    hstart = 1'b0;
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (done_cnt[d] !== 1) begin
        miscompares++;
        $display("FAIL done_count dut=%0d got %0d required 1", d, done_cnt[d]);
      end
    end
  endtask

  task automatic load_basic_roms();
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 16; r++) rom[d][r] = '0;
    rom[0][0] = 16'h0003;
    rom[2][0] = 16'h0003;
    rom[3][0] = 16'h0003;
    for (int r = 0; r < 16; r++) rom[1][r] = 16'h0001 << r;
  endtask

  task automatic randomize_roms();
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 16; r++) rom[d][r] = 16'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ((gfx_w | ip_w | done_w) !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs gfx=%b in_progress=%b done=%b required 0", gfx_w, ip_w, done_w);
    end
    vectors++;
    if ({if_a.rom_addr, if_b.rom_addr, if_c.rom_addr, if_d.rom_addr} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_rom_addr got %h/%h/%h/%h required 0", if_a.rom_addr, if_b.rom_addr, if_c.rom_addr, if_d.rom_addr);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ip_w !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_hold in_progress=%b required 0000", ip_w);
    end
  endtask

  task automatic test_defaults();
    load_basic_roms();
    run_frame(4'b0010, 4'b0010, -1, -1);
    vectors++;
    if (keep_g[0][0] !== LINE0_1X) begin
      miscompares++;
      $display("FAIL basic_line0 got %h required %h", keep_g[0][0], LINE0_1X);
    end
    vectors++;
    if (keep_g[0][15] !== LINE0_1X) begin
      miscompares++;
      $display("FAIL basic_line15 got %h required %h", keep_g[0][15], LINE0_1X);
    end
    for (int y = 0; y < 16; y++) begin
      vectors++;
      if (keep_a[0][y] !== ((y < 8) ? y : 15 - y)) begin
        miscompares++;
        $display("FAIL basic_addr line=%0d got %0d required %0d", y, keep_a[0][y], (y < 8) ? y : 15 - y);
      end
      vectors++;
      if (keep_a[1][y] !== 15 - y || keep_g[1][y] !== (64'd1 << (HS + 1 + y))) begin
        miscompares++;
        $display("FAIL flip_diag line=%0d got addr %0d gfx %h required addr %0d gfx %h",
                 y, keep_a[1][y], keep_g[1][y], 15 - y, 64'd1 << (HS + 1 + y));
      end
      vectors++;
      if (keep_g[3][y] !== keep_g[0][y]) begin
        miscompares++;
        $display("FAIL latency_image line=%0d got %h required %h", y, keep_g[3][y], keep_g[0][y]);
      end
    end
    vectors++;
    if (keep_g[2][0] !== LINE0_2X) begin
      miscompares++;
      $display("FAIL scale_line0 got %h required %h", keep_g[2][0], LINE0_2X);
    end
    for (int y = 0; y < 32; y++) begin
      vectors++;
      if (keep_a[2][y] !== (((y >> 1) < 8) ? (y >> 1) : 15 - (y >> 1))) begin
        miscompares++;
        $display("FAIL scale_addr line=%0d got %0d required %0d", y, keep_a[2][y],
                 ((y >> 1) < 8) ? (y >> 1) : 15 - (y >> 1));
      end
    end
    vectors++;
    if (keep_f[3][0] !== 3 || keep_f[0][0] !== 1) begin
      miscompares++;
      $display("FAIL fetch_states got lat2=%0d lat0=%0d required 3 and 1", keep_f[3][0], keep_f[0][0]);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      randomize_roms();
      run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), -1, -1);
    end
  endtask

  task automatic test_reset_mid_draw();
    randomize_roms();
    run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 5, -1);
    run_frame(4'b0000, 4'b0000, -1, -1);
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (keep_a[d][0] !== 0) begin
        miscompares++;
        $display("FAIL restart_addr dut=%0d got %0d required 0", d, keep_a[d][0]);
      end
    end
  endtask

  task automatic test_ignored_midframe();
    load_basic_roms();
    run_frame(4'b0010, 4'b0010, -1, 3);
    vectors++;
    if (keep_g[0][3] !== 64'd0 || keep_g[0][15] !== LINE0_1X) begin
      miscompares++;
      $display("FAIL glitch_image got line3 %h line15 %h required 0 and %h", keep_g[0][3], keep_g[0][15], LINE0_1X);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    vstart = 1'b0;
    load = 1'b0;
    hstart = 1'b0;
    hf_v = '0;
    vf_v = '0;
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 16; r++) rom[d][r] = '0;
    #1;
    test_reset();
    test_defaults();
    test_random();
    test_reset_mid_draw();
    test_ignored_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
